pmp_region_programmer: RTL and testbench

- Machine-mode configuration initiator for the pmp checker. It converts a high-level region request (entry, base, log2 size, permissions, lock) into the CSR write sequence the pmp expects.
- Sequence: read pmpcfg0, validate, write pmpaddrN, read-modify-write pmpcfg0.
- Sits between the trap/boot firmware request path and the pmp CSR port (wr_en/rw_addr/wdata/rdata).

---
 rtl/pmp_region_programmer_pkg.sv | 51 +++++
 rtl/pmp_region_programmer_napot.sv | 27 ++
 rtl/pmp_region_programmer.sv | 171 +++++++++++++++++
 tb/tb_pmp_region_programmer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmp_region_programmer_pkg.sv
// Shared types for the pmp region programmer: CSR addresses, pmpcfg layout,
// result codes and the latched request record.
package pmp_region_programmer_pkg;

   localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
   localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;

   typedef enum logic [1:0] {
      A_OFF   = 2'd0,
      A_TOR   = 2'd1,
      A_NA4   = 2'd2,
      A_NAPOT = 2'd3
   } pmp_amode_e;

   typedef struct packed {
      logic       lock;
      logic [1:0] zero;
      pmp_amode_e a;
      logic       x;
      logic       w;
      logic       r;
   } pmpcfg_t;

   typedef enum logic [2:0] {
      PMP_OK         = 3'd0,
      PMP_BAD_ENTRY  = 3'd1,
      PMP_BAD_SIZE   = 3'd2,
      PMP_MISALIGNED = 3'd3,
      PMP_BAD_PERM   = 3'd4,
      PMP_LOCKED     = 3'd5
   } pmp_prog_err_e;

   typedef struct packed {
      logic [1:0]  entry;
      logic [31:0] base;
      logic [5:0]  size_log2;
      logic [2:0]  perm;
      logic        lock;
      logic        off;
   } pmp_region_req_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CHECK   = 3'd1,
      ST_RD_CFG  = 3'd2,
      ST_WR_ADDR = 3'd3,
      ST_WR_CFG  = 3'd4,
      ST_RESP    = 3'd5
   } prog_state_e;

endpackage

// File: rtl/pmp_region_programmer_napot.sv
// Combinational region encoder: (base, log2 size) -> pmpaddr value, A mode
// and the size/alignment legality flags.
module pmp_napot_encode
   import pmp_region_programmer_pkg::*;
(
   input  logic [31:0] base,
   input  logic [5:0]  size_log2,
   output logic [31:0] pmpaddr,
   output pmp_amode_e  amode,
   output logic        misaligned,
   output logic        bad_size
);

   logic [31:0] align_mask;
   logic [31:0] napot_ones;

   always_comb begin
      bad_size   = (size_log2 < 6'd2) || (size_log2 > 6'd32);
      align_mask = (size_log2 >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << size_log2) - 32'd1);
      misaligned = !bad_size && ((base & align_mask) != 32'd0);
      // NAPOT encodes size as trailing ones below the word-aligned base
      napot_ones = (size_log2 >= 6'd3) ? ((32'd1 << (size_log2 - 6'd3)) - 32'd1) : 32'd0;
      pmpaddr    = (base >> 2) | napot_ones;
      amode      = (size_log2 == 6'd2) ? A_NA4 : A_NAPOT;
   end

endmodule

// File: rtl/pmp_region_programmer.sv
// Turns a region request into the pmpcfg0 read, pmpaddrN write and pmpcfg0
// read-modify-write sequence on the pmp CSR port.
//
// state   | meaning
// IDLE    | waiting for a request, req_ready high
// CHECK   | validate latched request, pick encodings
// RD_CFG  | present pmpcfg0 address, capture rdata, test L bit
// WR_ADDR | write pmpaddrN
// WR_CFG  | write pmpcfg0 with the entry byte replaced
// RESP    | hold response until resp_ready
module pmp_region_programmer
   import pmp_region_programmer_pkg::*;
#(
   parameter int          NUM_ENTRIES = 4,
   parameter logic [11:0] CFG_BASE    = CSR_PMPCFG0,
   parameter logic [11:0] ADDR_BASE   = CSR_PMPADDR0
)
(
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_entry,
   input  logic [31:0] req_base,
   input  logic [5:0]  req_size_log2,
   input  logic [2:0]  req_perm,
   input  logic        req_lock,
   input  logic        req_off,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [2:0]  resp_err,
   output logic        busy,
   output logic        wr_en,
   output logic [31:0] rw_addr,
   output logic [31:0] wdata,
   input  logic [31:0] rdata
);

   prog_state_e     state_q, state_d;
   pmp_prog_err_e   err_q, err_d, check_err;
   pmp_region_req_t req_q;
   logic [31:0]     cfg_q;

   logic [31:0] enc_addr;
   pmp_amode_e  enc_amode;
   logic        enc_misaligned;
   logic        enc_bad_size;

   logic        wr_en_d;
   logic [31:0] rw_addr_d;
   logic [31:0] wdata_d;
   logic [31:0] cfg_src;
   logic [31:0] cfg_merged;
   pmpcfg_t     cfg_byte;

   pmp_napot_encode u_encode (
      .base       (req_q.base),
      .size_log2  (req_q.size_log2),
      .pmpaddr    (enc_addr),
      .amode      (enc_amode),
      .misaligned (enc_misaligned),
      .bad_size   (enc_bad_size)
   );

   always_comb begin
      check_err = PMP_OK;
      if ({30'd0, req_q.entry} >= NUM_ENTRIES)
         check_err = PMP_BAD_ENTRY;
      else if (enc_bad_size)
         check_err = PMP_BAD_SIZE;
      else if (enc_misaligned)
         check_err = PMP_MISALIGNED;
      else if (req_q.perm[1] && !req_q.perm[0])
         check_err = PMP_BAD_PERM;
   end

   // In RD_CFG the off path jumps straight to WR_CFG, so merge from live rdata
   always_comb begin
      cfg_src    = (state_q == ST_RD_CFG) ? rdata : cfg_q;
      cfg_byte   = '{lock: req_q.lock, zero: 2'b00,
                     a: (req_q.off ? A_OFF : enc_amode),
                     x: req_q.perm[2], w: req_q.perm[1], r: req_q.perm[0]};
      cfg_merged = cfg_src;
      cfg_merged[{req_q.entry, 3'b000} +: 8] = cfg_byte;
   end

   always_comb begin
      state_d   = state_q;
      err_d     = err_q;
      wr_en_d   = 1'b0;
      rw_addr_d = 32'd0;
      wdata_d   = 32'd0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            err_d = check_err;
            if (check_err != PMP_OK) begin
               state_d = ST_RESP;
            end else begin
               state_d   = ST_RD_CFG;
               rw_addr_d = {20'd0, CFG_BASE};
            end
         end
         ST_RD_CFG: begin
            if (rdata[{req_q.entry, 3'd7}]) begin
               err_d   = PMP_LOCKED;
               state_d = ST_RESP;
            end else if (req_q.off) begin
               state_d   = ST_WR_CFG;
               wr_en_d   = 1'b1;
               rw_addr_d = {20'd0, CFG_BASE};
               wdata_d   = cfg_merged;
            end else begin
               state_d   = ST_WR_ADDR;
               wr_en_d   = 1'b1;
               rw_addr_d = {20'd0, ADDR_BASE} + {30'd0, req_q.entry};
               wdata_d   = enc_addr;
            end
         end
         ST_WR_ADDR: begin
            state_d   = ST_WR_CFG;
            wr_en_d   = 1'b1;
            rw_addr_d = {20'd0, CFG_BASE};
            wdata_d   = cfg_merged;
         end
         ST_WR_CFG: begin
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (resp_ready) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         err_q      <= PMP_OK;
         req_q      <= '0;
         cfg_q      <= 32'd0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 3'd0;
         busy       <= 1'b0;
         wr_en      <= 1'b0;
         rw_addr    <= 32'd0;
         wdata      <= 32'd0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         if (state_q == ST_IDLE && req_valid)
            req_q <= '{entry: req_entry, base: req_base, size_log2: req_size_log2,
                       perm: req_perm, lock: req_lock, off: req_off};
         if (state_q == ST_RD_CFG)
            cfg_q <= rdata;
         req_ready  <= (state_d == ST_IDLE);
         resp_valid <= (state_d == ST_RESP);
         resp_err   <= (state_d == ST_RESP) ? err_d : PMP_OK;
         busy       <= (state_d != ST_IDLE);
         wr_en      <= wr_en_d;
         rw_addr    <= rw_addr_d;
         wdata      <= wdata_d;
      end
   end

endmodule

// File: tb/tb_pmp_region_programmer.sv
// Bench for pmp_region_programmer: directed scenarios plus randomized requests
// checked against an arithmetic model of the region-programming rules.
module tb_pmp_region_programmer;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_entry;
   logic [31:0] req_base;
   logic [5:0]  req_size_log2;
   logic [2:0]  req_perm;
   logic        req_lock;
   logic        req_off;
   logic        resp_valid;
   logic        resp_ready;
   logic [2:0]  resp_err;
   logic        busy;
   logic        wr_en;
   logic [31:0] rw_addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   int n_checks = 0;
   int n_pass   = 0;

   // simple pmp CSR target
   logic [31:0] dev_cfg = 32'd0;
   logic [31:0] dev_addr [4];
   logic        dev_load = 1'b0;
   logic [31:0] dev_load_val = 32'd0;
   int          cfg_wr_total = 0;

   assign rdata = (rw_addr == 32'h3A0) ? dev_cfg : 32'd0;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (dev_load)
         dev_cfg <= dev_load_val;
      else if (wr_en && rw_addr == 32'h3A0)
         dev_cfg <= wdata;
      if (wr_en && rw_addr == 32'h3A0)
         cfg_wr_total <= cfg_wr_total + 1;
      if (wr_en && rw_addr >= 32'h3B0 && rw_addr <= 32'h3B3)
         dev_addr[rw_addr[1:0]] <= wdata;
   end

   pmp_region_programmer dut (
      .clock         (clock),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_entry     (req_entry),
      .req_base      (req_base),
      .req_size_log2 (req_size_log2),
      .req_perm      (req_perm),
      .req_lock      (req_lock),
      .req_off       (req_off),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_err      (resp_err),
      .busy          (busy),
      .wr_en         (wr_en),
      .rw_addr       (rw_addr),
      .wdata         (wdata),
      .rdata         (rdata)
   );

   int          obs_resp_at;
   int          obs_err;
   int          obs_wr_cnt;
   int          obs_rd_seen;
   logic        obs_ready_after;
   logic [31:0] obs_wr_addr [4];
   logic [31:0] obs_wr_data [4];
   int          obs_wr_at [4];

   task automatic preload(input logic [31:0] v);
      @(negedge clock);
      dev_load = 1'b1;
      dev_load_val = v;
      @(negedge clock);
      dev_load = 1'b0;
   endtask

   // Issue one request from IDLE and record what the DUT does, cycle by cycle
   task automatic run_req(input logic [1:0] e, input logic [31:0] b, input logic [5:0] k,
                          input logic [2:0] p, input logic l, input logic off);
      obs_resp_at = -1;
      obs_err = -1;
      obs_wr_cnt = 0;
      obs_rd_seen = 0;
      obs_ready_after = 1'b0;
      @(negedge clock);
      req_valid = 1'b1;
      req_entry = e;
      req_base = b;
      req_size_log2 = k;
      req_perm = p;
      req_lock = l;
      req_off = off;
      @(negedge clock);
      req_valid = 1'b0;
      req_entry = 2'($urandom);
      req_base = $urandom;
      req_size_log2 = 6'($urandom);
      req_perm = 3'($urandom);
      req_lock = 1'($urandom);
      req_off = 1'($urandom);
      for (int i = 1; i <= 30; i++) begin
         if (wr_en) begin
            if (obs_wr_cnt < 4) begin
               obs_wr_addr[obs_wr_cnt] = rw_addr;
               obs_wr_data[obs_wr_cnt] = wdata;
               obs_wr_at[obs_wr_cnt] = i;
            end
            obs_wr_cnt++;
         end else if (rw_addr == 32'h3A0) begin
            obs_rd_seen = 1;
         end
         if (resp_valid) begin
            obs_resp_at = i;
            obs_err = int'(resp_err);
            break;
         end
         @(negedge clock);
      end
      if (obs_resp_at > 0 && resp_ready) begin
         @(negedge clock);
         obs_ready_after = req_ready;
      end
   endtask

   // Reference rules for one request against the current pmpcfg0 contents
   task automatic model(input logic [1:0] e, input logic [31:0] b, input int k,
                        input logic [2:0] p, input logic l, input logic off,
                        input logic [31:0] cfg_in,
                        output int err, output int lat, output int nwr,
                        output logic [31:0] cfg_out, output logic [31:0] addr_out);
      longint unsigned bb, sz;
      int a;
      bb = {32'd0, b};
      err = 0;
      if (int'(e) >= 4) err = 1;
      else if (k < 2 || k > 32) err = 2;
      else begin
         sz = 64'd1 << k;
         if ((bb % sz) != 0) err = 3;
         else if (p[1] == 1'b1 && p[0] == 1'b0) err = 4;
         else if (cfg_in[8*int'(e)+7] == 1'b1) err = 5;
      end
      cfg_out = cfg_in;
      addr_out = 32'd0;
      if (err == 0) begin
         a = off ? 0 : ((k == 2) ? 2 : 3);
         cfg_out[8*int'(e) +: 8] = 8'((l ? 128 : 0) + a * 8 + int'(p));
         if (k == 2) addr_out = 32'(bb / 4);
         else addr_out = 32'(bb / 4 + ((64'd1 << (k - 3)) - 1));
      end
      lat = (err == 0) ? (off ? 4 : 5) : ((err == 5) ? 3 : 2);
      nwr = (err == 0) ? (off ? 1 : 2) : 0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clock);
      n_checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL reset_hs: ready=%b resp_valid=%b busy=%b want 1 0 0", req_ready, resp_valid, busy);
      else n_pass++;
      n_checks++;
      if (wr_en !== 1'b0 || rw_addr !== 32'd0 || wdata !== 32'd0 || resp_err !== 3'd0)
         $display("FAIL reset_csr: wr_en=%b addr=%h wdata=%h err=%0d want all zero", wr_en, rw_addr, wdata, resp_err);
      else n_pass++;
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_napot_write();
      preload(32'd0);
      run_req(2'd0, 32'h8000_0000, 6'd12, 3'b101, 1'b0, 1'b0);
      n_checks++;
      if (obs_wr_cnt !== 2 || obs_wr_at[0] !== 3 || obs_wr_addr[0] !== 32'h3B0 || obs_wr_data[0] !== 32'h2000_01FF)
         $display("FAIL napot_addr_wr: cnt=%0d at=%0d addr=%h data=%h want 2 3 3b0 200001ff",
                  obs_wr_cnt, obs_wr_at[0], obs_wr_addr[0], obs_wr_data[0]);
      else n_pass++;
      n_checks++;
      if (obs_wr_at[1] !== 4 || obs_wr_addr[1] !== 32'h3A0 || obs_wr_data[1] !== 32'h0000_001D)
         $display("FAIL napot_cfg_wr: at=%0d addr=%h data=%h want 4 3a0 0000001d",
                  obs_wr_at[1], obs_wr_addr[1], obs_wr_data[1]);
      else n_pass++;
      n_checks++;
      if (obs_resp_at !== 5 || obs_err !== 0 || obs_ready_after !== 1'b1)
         $display("FAIL napot_resp: at=%0d err=%0d ready_after=%b want 5 0 1", obs_resp_at, obs_err, obs_ready_after);
      else n_pass++;
   endtask

   task automatic test_na4_merge();
      preload(32'h0000_001D);
      run_req(2'd2, 32'h0000_1000, 6'd2, 3'b001, 1'b0, 1'b0);
      n_checks++;
      if (obs_wr_cnt !== 2 || obs_wr_addr[0] !== 32'h3B2 || obs_wr_data[0] !== 32'h0000_0400)
         $display("FAIL na4_addr_wr: cnt=%0d addr=%h data=%h want 2 3b2 00000400", obs_wr_cnt, obs_wr_addr[0], obs_wr_data[0]);
      else n_pass++;
      n_checks++;
      if (obs_wr_addr[1] !== 32'h3A0 || obs_wr_data[1] !== 32'h0011_001D || obs_resp_at !== 5 || obs_err !== 0)
         $display("FAIL na4_cfg_wr: addr=%h data=%h resp_at=%0d err=%0d want 3a0 0011001d 5 0",
                  obs_wr_addr[1], obs_wr_data[1], obs_resp_at, obs_err);
      else n_pass++;
   endtask

   task automatic test_misaligned();
      preload(32'd0);
      run_req(2'd1, 32'h0000_1800, 6'd12, 3'b011, 1'b0, 1'b0);
      n_checks++;
      if (obs_err !== 3 || obs_resp_at !== 2 || obs_wr_cnt !== 0 || obs_rd_seen !== 0)
         $display("FAIL misaligned: err=%0d at=%0d writes=%0d rd_seen=%0d want 3 2 0 0",
                  obs_err, obs_resp_at, obs_wr_cnt, obs_rd_seen);
      else n_pass++;
   endtask

   task automatic test_locked();
      preload(32'h0000_8000);
      run_req(2'd1, 32'h0000_2000, 6'd12, 3'b001, 1'b0, 1'b0);
      n_checks++;
      if (obs_err !== 5 || obs_resp_at !== 3 || obs_wr_cnt !== 0 || obs_rd_seen !== 1)
         $display("FAIL locked: err=%0d at=%0d writes=%0d rd_seen=%0d want 5 3 0 1",
                  obs_err, obs_resp_at, obs_wr_cnt, obs_rd_seen);
      else n_pass++;
   endtask

   task automatic test_boundaries();
      preload(32'h0000_001D);
      run_req(2'd3, 32'h1234_5678, 6'd40, 3'b011, 1'b1, 1'b1);
      n_checks++;
      if (obs_err !== 2 || obs_resp_at !== 2) $display("FAIL size_too_big: err=%0d at=%0d want 2 2", obs_err, obs_resp_at);
      else n_pass++;
      run_req(2'd0, 32'h0000_0003, 6'd1, 3'b010, 1'b0, 1'b0);
      n_checks++;
      if (obs_err !== 2 || obs_resp_at !== 2) $display("FAIL size_too_small: err=%0d at=%0d want 2 2", obs_err, obs_resp_at);
      else n_pass++;
      run_req(2'd0, 32'h0000_0100, 6'd8, 3'b010, 1'b0, 1'b0);
      n_checks++;
      if (obs_err !== 4 || obs_resp_at !== 2) $display("FAIL bad_perm: err=%0d at=%0d want 4 2", obs_err, obs_resp_at);
      else n_pass++;
      run_req(2'd3, 32'hFFFF_0000, 6'd2, 3'b011, 1'b1, 1'b1);
      n_checks++;
      if (obs_wr_cnt !== 1 || obs_wr_at[0] !== 3 || obs_wr_addr[0] !== 32'h3A0 || obs_wr_data[0] !== 32'h8300_001D)
         $display("FAIL off_cfg_wr: cnt=%0d at=%0d addr=%h data=%h want 1 3 3a0 8300001d",
                  obs_wr_cnt, obs_wr_at[0], obs_wr_addr[0], obs_wr_data[0]);
      else n_pass++;
      n_checks++;
      if (obs_resp_at !== 4 || obs_err !== 0) $display("FAIL off_resp: at=%0d err=%0d want 4 0", obs_resp_at, obs_err);
      else n_pass++;
      preload(32'd0);
      run_req(2'd1, 32'h0000_0000, 6'd32, 3'b111, 1'b0, 1'b0);
      n_checks++;
      if (obs_wr_cnt !== 2 || obs_wr_addr[0] !== 32'h3B1 || obs_wr_data[0] !== 32'h1FFF_FFFF || obs_wr_data[1] !== 32'h0000_1F00)
         $display("FAIL full_range: cnt=%0d addr=%h data0=%h data1=%h want 2 3b1 1fffffff 00001f00",
                  obs_wr_cnt, obs_wr_addr[0], obs_wr_data[0], obs_wr_data[1]);
      else n_pass++;
   endtask

   task automatic test_reset_mid_op();
      int cfg_before;
      logic saw_resp;
      preload(32'd0);
      cfg_before = cfg_wr_total;
      @(negedge clock);
      req_valid = 1'b1;
      req_entry = 2'd1;
      req_base = 32'h0001_0000;
      req_size_log2 = 6'd16;
      req_perm = 3'b011;
      req_lock = 1'b0;
      req_off = 1'b0;
      @(negedge clock);
      req_valid = 1'b0;
      repeat (2) @(negedge clock);
      n_checks++;
      if (wr_en !== 1'b1 || rw_addr !== 32'h3B1) $display("FAIL midop_wr_addr: wr_en=%b addr=%h want 1 3b1", wr_en, rw_addr);
      else n_pass++;
      reset = 1'b0;
      @(negedge clock);
      n_checks++;
      if (wr_en !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL midop_abort: wr_en=%b ready=%b resp_valid=%b busy=%b want 0 1 0 0", wr_en, req_ready, resp_valid, busy);
      else n_pass++;
      reset = 1'b1;
      saw_resp = 1'b0;
      repeat (6) begin
         @(negedge clock);
         if (resp_valid || wr_en) saw_resp = 1'b1;
      end
      n_checks++;
      if (saw_resp !== 1'b0 || cfg_wr_total != cfg_before)
         $display("FAIL midop_quiet: activity=%b cfg_writes=%0d want 0 %0d", saw_resp, cfg_wr_total, cfg_before);
      else n_pass++;
   endtask

   task automatic test_back_pressure();
      int cfg_before;
      preload(32'd0);
      resp_ready = 1'b0;
      run_req(2'd2, 32'h0000_4000, 6'd14, 3'b011, 1'b0, 1'b0);
      n_checks++;
      if (obs_resp_at !== 5 || obs_err !== 0) $display("FAIL bp_first: at=%0d err=%0d want 5 0", obs_resp_at, obs_err);
      else n_pass++;
      cfg_before = cfg_wr_total;
      req_valid = 1'b1;
      req_entry = 2'd0;
      req_base = 32'h0000_0010;
      req_size_log2 = 6'd3;
      req_perm = 3'b001;
      for (int c = 2; c <= 4; c++) begin
         @(negedge clock);
         n_checks++;
         if (resp_valid !== 1'b1 || resp_err !== 3'd0 || req_ready !== 1'b0)
            $display("FAIL bp_hold cycle %0d: resp_valid=%b err=%0d ready=%b want 1 0 0", c, resp_valid, resp_err, req_ready);
         else n_pass++;
      end
      resp_ready = 1'b1;
      req_valid = 1'b0;
      @(negedge clock);
      n_checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL bp_release: ready=%b resp_valid=%b want 1 0", req_ready, resp_valid);
      else n_pass++;
      repeat (4) @(negedge clock);
      n_checks++;
      if (busy !== 1'b0 || cfg_wr_total != cfg_before)
         $display("FAIL bp_ignored_req: busy=%b cfg_writes=%0d want 0 %0d", busy, cfg_wr_total, cfg_before);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] exp_cfg, exp_cfg_next, exp_addr;
      logic [1:0]  e;
      logic [31:0] b;
      int          k, err, lat, nwr;
      logic [2:0]  p;
      logic        l, off;
      exp_cfg = 32'd0;
      for (int it = 0; it < 60; it++) begin
         if (it % 10 == 0) begin
            exp_cfg = $urandom & 32'h7F7F_7F7F;
            if ($urandom_range(0, 2) == 0) exp_cfg[8*$urandom_range(0, 3)+7] = 1'b1;
            preload(exp_cfg);
         end
         e = 2'($urandom);
         k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(2, 32));
         b = $urandom;
         if ($urandom_range(0, 4) != 0 && k >= 2 && k <= 32)
            b = (k == 32) ? 32'd0 : (b & ~32'((64'd1 << k) - 1));
         p = 3'($urandom);
         l = ($urandom_range(0, 7) == 0);
         off = ($urandom_range(0, 4) == 0);
         model(e, b, k, p, l, off, exp_cfg, err, lat, nwr, exp_cfg_next, exp_addr);
         run_req(e, b, 6'(k), p, l, off);
         n_checks++;
         if (obs_err != err || obs_resp_at != lat || obs_wr_cnt != nwr)
            $display("FAIL rand_resp it%0d: err=%0d at=%0d writes=%0d want %0d %0d %0d",
                     it, obs_err, obs_resp_at, obs_wr_cnt, err, lat, nwr);
         else n_pass++;
         n_checks++;
         if (dev_cfg !== exp_cfg_next || obs_ready_after !== 1'b1)
            $display("FAIL rand_cfg it%0d: cfg=%h ready_after=%b want %h 1", it, dev_cfg, obs_ready_after, exp_cfg_next);
         else n_pass++;
         if (nwr == 2) begin
            n_checks++;
            if (obs_wr_addr[0] !== 32'h3B0 + 32'(e) || dev_addr[e] !== exp_addr)
               $display("FAIL rand_addr it%0d: first_wr=%h pmpaddr=%h want %h %h",
                        it, obs_wr_addr[0], dev_addr[e], 32'h3B0 + 32'(e), exp_addr);
            else n_pass++;
         end
         exp_cfg = exp_cfg_next;
      end
   endtask

   initial begin
      reset = 1'b0;
      req_valid = 1'b0;
      req_entry = 2'd0;
      req_base = 32'd0;
      req_size_log2 = 6'd0;
      req_perm = 3'd0;
      req_lock = 1'b0;
      req_off = 1'b0;
      resp_ready = 1'b1;
      test_reset();
      test_napot_write();
      test_na4_merge();
      test_misaligned();
      test_locked();
      test_boundaries();
      test_reset_mid_op();
      test_back_pressure();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
